// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle RV32I controller: FSM states, datapath
// select encodings, opcode values and the decoded instruction class.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, BRTGT, WB, TRAP, HALT
  } state_e;

  typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_ALU = 2'b01, PC_TRAP = 2'b10} pc_src_e;
  typedef enum logic [1:0] {A_RS1 = 2'b00, A_PC = 2'b01, A_ZERO = 2'b10} alu_a_e;
  typedef enum logic [1:0] {B_RS2 = 2'b00, B_IMM = 2'b01} alu_b_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MDR = 2'b01, WB_PC4 = 2'b10} wb_sel_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // One-hot instruction class; all-zero means the opcode is not recognised.
  typedef struct packed {
    logic op;
    logic op_imm;
    logic load;
    logic store;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic branch;
    logic system;
  } cls_t;

endpackage

// File: rtl/instr_classify.sv
// Combinational opcode classifier: one-hot instruction class plus an
// illegal flag for opcodes outside the supported RV32I set.
module instr_classify
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    cls = '0;
    case (opcode)
      OPC_OP:     cls.op     = 1'b1;
      OPC_OP_IMM: cls.op_imm = 1'b1;
      OPC_LOAD:   cls.load   = 1'b1;
      OPC_STORE:  cls.store  = 1'b1;
      OPC_JAL:    cls.jal    = 1'b1;
      OPC_JALR:   cls.jalr   = 1'b1;
      OPC_LUI:    cls.lui    = 1'b1;
      OPC_AUIPC:  cls.auipc  = 1'b1;
      OPC_BRANCH: cls.branch = 1'b1;
      OPC_SYSTEM: cls.system = 1'b1;
      default:    cls = '0;
    endcase
    illegal = ~|cls;
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM: steps each instruction through FETCH, DECODE,
// EXEC, MEM/BRTGT and WB, driving datapath selects, enables and handshakes.
module mc_control
  import ctrl_pkg::*;
#(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic       alu_force_add,
  output logic       aluout_we,
  output logic       mdr_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       halted,
  output logic       retire
);

  state_e state_q, state_d;
  cls_t   cls_q, cls_d;
  cls_t   dec_cls;
  logic   dec_illegal;

  instr_classify u_classify (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      state_q <= FETCH;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = PC_SEQ;
    alu_a_sel     = A_RS1;
    alu_b_sel     = B_RS2;
    alu_force_add = 1'b0;
    aluout_we     = 1'b0;
    mdr_we        = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    illegal       = 1'b0;
    halted        = 1'b0;
    retire        = 1'b0;

    // Outputs stay quiet for the whole reset cycle so abandoned requests drop at once.
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            pc_src  = PC_SEQ;
            state_d = DECODE;
          end
        end

        DECODE: begin
          cls_d = dec_cls;
          if (dec_cls.system) begin
            if (funct3 == 3'b000) begin
              state_d = HALT;
            end else begin
              retire  = 1'b1;
              state_d = FETCH;
            end
          end else if (dec_illegal) begin
            if (TRAP_ILLEGAL) begin
              state_d = TRAP;
            end else begin
              retire  = 1'b1;
              state_d = FETCH;
            end
          end else begin
            state_d = EXEC;
          end
        end

        EXEC: begin
          aluout_we = 1'b1;
          if (cls_q.lui) alu_a_sel = A_ZERO;
          else if (cls_q.auipc || cls_q.jal) alu_a_sel = A_PC;
          alu_b_sel = (cls_q.op || cls_q.branch) ? B_RS2 : B_IMM;
          if (cls_q.jal || cls_q.jalr) begin
            pc_we  = 1'b1;
            pc_src = PC_ALU;
          end
          if (cls_q.load || cls_q.store) begin
            state_d = MEM;
          end else if (cls_q.branch) begin
            if (branch_taken) begin
              state_d = BRTGT;
            end else begin
              retire  = 1'b1;
              state_d = FETCH;
            end
          end else if (cls_q.system) begin
            // Unreachable: SYSTEM never leaves DECODE towards EXEC.
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end

        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls_q.store;
          if (dmem_ready) begin
            if (cls_q.store) begin
              retire  = 1'b1;
              state_d = FETCH;
            end else begin
              mdr_we  = 1'b1;
              state_d = WB;
            end
          end
        end

        BRTGT: begin
          alu_a_sel     = A_PC;
          alu_b_sel     = B_IMM;
          alu_force_add = 1'b1;
          pc_we         = 1'b1;
          pc_src        = PC_ALU;
          retire        = 1'b1;
          state_d       = FETCH;
        end

        WB: begin
          rf_we = 1'b1;
          if (cls_q.jal || cls_q.jalr) wb_sel = WB_PC4;
          else if (cls_q.load) wb_sel = WB_MDR;
          retire  = 1'b1;
          state_d = FETCH;
        end

        TRAP: begin
          pc_we   = 1'b1;
          pc_src  = PC_TRAP;
          illegal = 1'b1;
          state_d = FETCH;
        end

        HALT: begin
          halted = 1'b1;
        end

        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks each instruction class cycle by cycle
// and compares the full control word against hand-written expectations.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       imem_req, imem_ready;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       ir_we, pc_we;
  logic [1:0] pc_src, alu_a_sel, alu_b_sel, wb_sel;
  logic       alu_force_add, aluout_we, mdr_we, rf_we;
  logic       illegal, halted, retire;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       ireq;
    logic       dreq;
    logic       dwe;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic [1:0] asel;
    logic [1:0] bsel;
    logic       fadd;
    logic       aluwe;
    logic       mdrwe;
    logic       rfwe;
    logic [1:0] wbsel;
    logic       ill;
    logic       hlt;
    logic       ret;
  } ctl_t;

  localparam ctl_t IDLE  = '0;
  localparam ctl_t FWAIT = '{ireq: 1'b1, default: 0};
  localparam ctl_t FGO   = '{ireq: 1'b1, irwe: 1'b1, pcwe: 1'b1, default: 0};

  ctl_t obs;
  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_a_sel,
                alu_b_sel, alu_force_add, aluout_we, mdr_we, rf_we, wb_sel,
                illegal, halted, retire};

  mc_control #(.TRAP_ILLEGAL(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .branch_taken  (branch_taken),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ready    (dmem_ready),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .alu_a_sel     (alu_a_sel),
    .alu_b_sel     (alu_b_sel),
    .alu_force_add (alu_force_add),
    .aluout_we     (aluout_we),
    .mdr_we        (mdr_we),
    .rf_we         (rf_we),
    .wb_sel        (wb_sel),
    .illegal       (illegal),
    .halted        (halted),
    .retire        (retire)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked 1 ns later, mid-cycle.
  task automatic cyc(input string tag, input ctl_t e);
    #1;
    check(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_go(input string tag, input logic [6:0] opc, input logic [2:0] f3);
    opcode     = opc;
    funct3     = f3;
    imem_ready = 1'b1;
    cyc(tag, FGO);
    imem_ready = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    opcode       = 7'b0;
    funct3       = 3'b0;
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
    dmem_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_quiet", IDLE);
    rst_n      = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;

    // R-type, one fetch wait state, ready left high through DECODE
    opcode = 7'b0110011;
    cyc("r_fetch_wait", FWAIT);
    imem_ready = 1'b1;
    cyc("r_fetch", FGO);
    cyc("r_decode", IDLE);
    imem_ready = 1'b0;
    cyc("r_exec", '{aluwe: 1'b1, default: 0});
    cyc("r_wb", '{rfwe: 1'b1, ret: 1'b1, default: 0});

    // LOAD with two data wait states; opcode scrambled after DECODE
    fetch_go("ld_fetch", 7'b0000011, 3'b010);
    cyc("ld_decode", IDLE);
    cyc("ld_exec", '{aluwe: 1'b1, bsel: 2'b01, default: 0});
    opcode = 7'b1111111;
    cyc("ld_mem_wait1", '{dreq: 1'b1, default: 0});
    cyc("ld_mem_wait2", '{dreq: 1'b1, default: 0});
    dmem_ready = 1'b1;
    cyc("ld_mem_done", '{dreq: 1'b1, mdrwe: 1'b1, default: 0});
    dmem_ready = 1'b0;
    cyc("ld_wb", '{rfwe: 1'b1, wbsel: 2'b01, ret: 1'b1, default: 0});

    // STORE, zero wait
    fetch_go("st_fetch", 7'b0100011, 3'b010);
    cyc("st_decode", IDLE);
    cyc("st_exec", '{aluwe: 1'b1, bsel: 2'b01, default: 0});
    dmem_ready = 1'b1;
    cyc("st_mem", '{dreq: 1'b1, dwe: 1'b1, ret: 1'b1, default: 0});
    dmem_ready = 1'b0;

    // BRANCH not taken, then taken
    fetch_go("bn_fetch", 7'b1100011, 3'b000);
    cyc("bn_decode", IDLE);
    branch_taken = 1'b0;
    cyc("bn_exec", '{aluwe: 1'b1, ret: 1'b1, default: 0});
    fetch_go("bt_fetch", 7'b1100011, 3'b001);
    cyc("bt_decode", IDLE);
    branch_taken = 1'b1;
    cyc("bt_exec", '{aluwe: 1'b1, default: 0});
    branch_taken = 1'b0;
    cyc("bt_brtgt", '{asel: 2'b01, bsel: 2'b01, fadd: 1'b1, pcwe: 1'b1,
                      pcsrc: 2'b01, ret: 1'b1, default: 0});

    // JAL / JALR / LUI / AUIPC operand and writeback selection
    fetch_go("jal_fetch", 7'b1101111, 3'b000);
    cyc("jal_decode", IDLE);
    cyc("jal_exec", '{aluwe: 1'b1, asel: 2'b01, bsel: 2'b01, pcwe: 1'b1,
                      pcsrc: 2'b01, default: 0});
    cyc("jal_wb", '{rfwe: 1'b1, wbsel: 2'b10, ret: 1'b1, default: 0});
    fetch_go("jalr_fetch", 7'b1100111, 3'b000);
    cyc("jalr_decode", IDLE);
    cyc("jalr_exec", '{aluwe: 1'b1, bsel: 2'b01, pcwe: 1'b1, pcsrc: 2'b01, default: 0});
    cyc("jalr_wb", '{rfwe: 1'b1, wbsel: 2'b10, ret: 1'b1, default: 0});
    fetch_go("lui_fetch", 7'b0110111, 3'b000);
    cyc("lui_decode", IDLE);
    cyc("lui_exec", '{aluwe: 1'b1, asel: 2'b10, bsel: 2'b01, default: 0});
    cyc("lui_wb", '{rfwe: 1'b1, ret: 1'b1, default: 0});
    fetch_go("auipc_fetch", 7'b0010111, 3'b000);
    cyc("auipc_decode", IDLE);
    cyc("auipc_exec", '{aluwe: 1'b1, asel: 2'b01, bsel: 2'b01, default: 0});
    cyc("auipc_wb", '{rfwe: 1'b1, ret: 1'b1, default: 0});

    // Non-halting SYSTEM retires straight from DECODE
    fetch_go("csr_fetch", 7'b1110011, 3'b001);
    cyc("csr_decode", '{ret: 1'b1, default: 0});

    // Illegal opcode traps: one illegal pulse, no retire
    fetch_go("ill_fetch", 7'b1111111, 3'b000);
    cyc("ill_decode", IDLE);
    cyc("ill_trap", '{pcwe: 1'b1, pcsrc: 2'b10, ill: 1'b1, default: 0});

    // Reset while a load is waiting in MEM
    cyc("ill_after_fetch", FWAIT);
    imem_ready = 1'b1;
    opcode     = 7'b0000011;
    cyc("rm_fetch", FGO);
    imem_ready = 1'b0;
    cyc("rm_decode", IDLE);
    cyc("rm_exec", '{aluwe: 1'b1, bsel: 2'b01, default: 0});
    cyc("rm_mem", '{dreq: 1'b1, default: 0});
    rst_n = 1'b0;
    cyc("rm_reset", IDLE);
    rst_n = 1'b1;
    cyc("rm_release", FWAIT);

    // ECALL halts; ready is ignored until reset
    imem_ready = 1'b1;
    opcode     = 7'b1110011;
    funct3     = 3'b000;
    cyc("ecall_fetch", FGO);
    cyc("ecall_decode", IDLE);
    for (int i = 0; i < 3; i++) cyc("halt_sticky", '{hlt: 1'b1, default: 0});
    rst_n = 1'b0;
    cyc("halt_reset", IDLE);
    rst_n      = 1'b1;
    imem_ready = 1'b0;
    cyc("halt_release", FWAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM for the RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback, driving datapath mux selects, register enables and the instruction/data memory handshakes. The ALU decoder still selects the ALU operation in EXEC; this block only chooses operand sources and forces ADD for branch-target computation. Sits between the IR/opcode fields and the multi-cycle datapath.

## Interface
- `TRAP_ILLEGAL`, 1: unknown opcode → 1 traps via TRAP; 0 → retired as no-op.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `opcode` in 7, `funct3` in 3: from IR, valid from DECODE onward.
- `branch_taken` in 1: ALU compare result after `inv_br`, sampled in EXEC.
- `imem_req` out 1, `imem_ready` in 1: fetch handshake.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_ready` in 1: data handshake, address = ALU-out register.
- `ir_we` out 1: latch IR and old_pc.
- `pc_we` out 1, `pc_src` out 2: 00 pc+4, 01 ALU result (combinational), 10 trap vector.
- `alu_a_sel` out 2: 00 rs1, 01 old_pc, 10 zero. `alu_b_sel` out 2: 00 rs2, 01 imm.
- `alu_force_add` out 1: override decoder to ADD.
- `aluout_we` out 1, `mdr_we` out 1: ALU-out / read-data registers.
- `rf_we` out 1, `wb_sel` out 2: 00 ALU-out, 01 MDR, 10 old_pc+4.
- `illegal` out 1 (1-cycle pulse), `halted` out 1 (sticky), `retire` out 1 (1-cycle pulse).

## Operation
- Outputs decoded from state (+ handshake inputs); all outputs 0 while `rst_n`=0. Reset state FETCH; unassigned outputs 0 in every state.
- FETCH: `imem_req`=1. On `imem_ready`: `ir_we`=1, `pc_we`=1, `pc_src`=00 → DECODE; else hold.
- DECODE: no writes. SYSTEM with funct3=000 → HALT; other SYSTEM → FETCH with `retire`; unknown opcode → TRAP (or FETCH + `retire` if `TRAP_ILLEGAL`=0); else → EXEC.
- EXEC: `aluout_we`=1. Operands: R a=rs1,b=rs2; I/LOAD/STORE/JALR a=rs1,b=imm; LUI a=zero,b=imm; AUIPC/JAL a=old_pc,b=imm; BRANCH a=rs1,b=rs2. JAL/JALR also `pc_we`=1, `pc_src`=01 (datapath clears bit 0 for JALR). Next: R/I/LUI/AUIPC/JAL/JALR → WB; LOAD/STORE → MEM; BRANCH → BRTGT if `branch_taken`, else FETCH with `retire`.
- MEM: `dmem_req`=1, `dmem_we`=store. On `dmem_ready`: load → `mdr_we`=1, → WB; store → FETCH with `retire`. Else hold.
- BRTGT: a=old_pc, b=imm, `alu_force_add`=1, `pc_we`=1, `pc_src`=01, `retire` → FETCH.
- WB: `rf_we`=1; `wb_sel` 10 for JAL/JALR, 01 for LOAD, else 00; `retire` → FETCH.
- TRAP: `pc_we`=1, `pc_src`=10, `illegal`=1 → FETCH. No `retire`.
- HALT: `halted`=1, no requests; exit only by reset.
- Opcode class latched at DECODE; later states do not re-decode `opcode`.

## Timing
- Handshake: req held high until ready; transfer on cycle with req&ready; ready without req ignored; req drops the cycle after the transfer.
- Minimum cycles (zero-wait memory): R/I/LUI/AUIPC/JAL/JALR 4, load 5, store 4, taken branch 4, not-taken branch 3, trap 3.
- Each wait cycle on `imem_ready`/`dmem_ready` adds exactly one cycle.
- `retire` asserted in the final state's cycle, exactly once per instruction.
- Reset mid-transaction: req deasserts in the reset cycle; memory tolerates abandoned requests; first `imem_req` in first cycle with `rst_n`=1.

## Structure
- Package `ctrl_pkg`: state enum (FETCH, DECODE, EXEC, MEM, BRTGT, WB, TRAP, HALT), encodings for `pc_src`, `alu_a_sel`, `alu_b_sel`, `wb_sel`. Opcode values from the shared opcode definitions.
- Sub-module `instr_classify`: combinational opcode → one-hot class + illegal flag, registered in DECODE.

## Test plan
- R-type 0110011, zero-wait: FETCH→DECODE→EXEC→WB; `rf_we`=1 with `wb_sel`=00 in cycle 4; `retire` once.
- LOAD 0000011, `dmem_ready` delayed 2 cycles: `dmem_req` high 3 cycles, `dmem_we`=0, `mdr_we` on ready cycle, WB `wb_sel`=01; total 7 cycles.
- BRANCH 1100011, `branch_taken`=0 then 1: 3 cycles no `pc_we` after fetch; taken → BRTGT `alu_force_add`=1, `pc_src`=01.
- JAL 1101111: EXEC `pc_we`=1 `pc_src`=01 a=01; WB `rf_we`=1 `wb_sel`=10.
- Opcode 1111111 with `TRAP_ILLEGAL`=1: `illegal` one pulse, `pc_src`=10, no `retire`; ECALL (1110011, funct3 000): `halted` sticky, no `imem_req` until reset.
- `rst_n` low during MEM with `dmem_req`=1: `dmem_req`=0 in that cycle; after release `imem_req`=1 immediately.
